// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between the CPU control unit and mem_responder
// Signals:
//   mem_read    read request, sampled by the responder only when idle
//   mem_write   write request, sampled by the responder only when idle
//   address     byte address, must be word aligned
//   write_data  write data, captured with the request
//   read_data   read result, held until the next successful read completes
//   mem_ready   one-cycle completion pulse (success or error)
//   mem_busy    high while a request is in flight
//   mem_error   one-cycle pulse coincident with mem_ready on a rejected request
// Modports: master = requester (CPU side), slave = responder (memory side).
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        mem_ready;
  logic        mem_busy;
  logic        mem_error;

  modport master (
    output mem_read, mem_write, address, write_data,
    input  read_data, mem_ready, mem_busy, mem_error
  );

  modport slave (
    input  mem_read, mem_write, address, write_data,
    output read_data, mem_ready, mem_busy, mem_error
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder for the multicycle CPU bus
// Accepts one read or write at a time, inserts WAIT_STATES cycles, then pulses
// mem_ready for one cycle. Misaligned, out-of-range or read+write requests are
// answered one cycle later with mem_ready and mem_error together.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset (storage array is not cleared)
//   bus    mem_responder_if.slave (request in, response out)
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input logic            clk,
  input logic            rst_n,
  mem_responder_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;
  logic          write_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          req;
  logic          req_bad;
  logic [AW-1:0] req_idx;

  assign req     = bus.mem_read | bus.mem_write;
  assign req_bad = (bus.mem_read & bus.mem_write)
                 | (bus.address[1:0] != 2'b00)
                 | (bus.address[31:2] >= 30'(DEPTH_WORDS));
  assign req_idx = bus.address[AW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      write_q       <= 1'b0;
      bus.read_data <= '0;
      bus.mem_ready <= 1'b0;
      bus.mem_busy  <= 1'b0;
      bus.mem_error <= 1'b0;
    end else begin
      // Completion pulses last exactly one cycle unless re-asserted below.
      bus.mem_ready <= 1'b0;
      bus.mem_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            if (req_bad) begin
              state         <= S_ERR;
              bus.mem_ready <= 1'b1;
              bus.mem_error <= 1'b1;
            end else begin
              addr_q       <= req_idx;
              data_q       <= bus.write_data;
              write_q      <= bus.mem_write;
              cnt          <= CW'(WAIT_STATES);
              bus.mem_busy <= 1'b1;
              if (WAIT_STATES == 0) begin
                // No wait states: go straight to RESP, so the read must use
                // the live address rather than the not-yet-captured one.
                state         <= S_RESP;
                bus.mem_ready <= 1'b1;
                if (!bus.mem_write) begin
                  bus.read_data <= mem[req_idx];
                end
              end else begin
                state <= S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state         <= S_RESP;
            bus.mem_ready <= 1'b1;
            if (!write_q) begin
              bus.read_data <= mem[addr_q];
            end
          end
        end
        S_RESP: begin
          state        <= S_IDLE;
          bus.mem_busy <= 1'b0;
        end
        S_ERR: begin
          state <= S_IDLE;
        end
        default: begin
          state        <= S_IDLE;
          bus.mem_busy <= 1'b0;
        end
      endcase
    end
  end

  // The write commits on the edge leaving RESP. An async reset forces the
  // state out of RESP immediately, so an aborted write never reaches the array.
  always_ff @(posedge clk) begin
    if (state == S_RESP && write_q) begin
      mem[addr_q] <= data_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder (WAIT_STATES=2 and 0)
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [int];
  logic [31:0] model0 [int];
  logic [31:0] last_rd;

  mem_responder_if bus ();
  mem_responder_if bus0 ();

  mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  always #5 clk = ~clk;

  task automatic drive(input int which, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (which == 0) begin
      bus.mem_read = rd; bus.mem_write = wr; bus.address = a; bus.write_data = d;
    end else begin
      bus0.mem_read = rd; bus0.mem_write = wr; bus0.address = a; bus0.write_data = d;
    end
  endtask

  // One-cycle request pulse, then wait (bounded) for mem_ready; lat=-1 on timeout.
  task automatic issue(input int which, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic err, output logic [31:0] rdata);
    logic rdy;
    @(negedge clk);
    drive(which, rd, wr, a, d);
    @(negedge clk);
    drive(which, 1'b0, 1'b0, a, d);
    lat = 1;
    rdy = (which == 0) ? bus.mem_ready : bus0.mem_ready;
    while (!rdy && lat < 20) begin
      @(negedge clk);
      lat++;
      rdy = (which == 0) ? bus.mem_ready : bus0.mem_ready;
    end
    if (!rdy) lat = -1;
    err   = (which == 0) ? bus.mem_error : bus0.mem_error;
    rdata = (which == 0) ? bus.read_data : bus0.read_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    total++;
    if ({bus.mem_ready, bus.mem_busy, bus.mem_error, bus.read_data} !== 35'd0) begin
      bad++;
      $display("FAIL reset_outs got=%b/%b/%b/%h want=0/0/0/0",
               bus.mem_ready, bus.mem_busy, bus.mem_error, bus.read_data);
    end
    total++;
    if ({bus0.mem_ready, bus0.mem_busy, bus0.mem_error, bus0.read_data} !== 35'd0) begin
      bad++;
      $display("FAIL reset_outs0 got=%b/%b/%b/%h want=0/0/0/0",
               bus0.mem_ready, bus0.mem_busy, bus0.mem_error, bus0.read_data);
    end
    rst_n = 1'b1;
    last_rd = 32'h0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({bus.mem_ready, bus.mem_busy, bus.mem_error} !== 3'b000) begin
        bad++;
        $display("FAIL idle_quiet[%0d] got=%b want=000", c,
                 {bus.mem_ready, bus.mem_busy, bus.mem_error});
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] wa [4];
    logic [31:0] wd [4];
    int          lat;
    logic        err;
    logic [31:0] rd;
    exp_t        e;
    wa[0] = 32'h10;  wd[0] = 32'hDEADBEEF;
    wa[1] = 32'h20;  wd[1] = 32'hA5A5A5A5;
    wa[2] = 32'h0;   wd[2] = 32'h11111111;
    wa[3] = 32'h3FC; wd[3] = 32'h22222222;
    for (int i = 0; i < 4; i++) begin
      model[int'(wa[i])] = wd[i];
      sb.push_back('{1'b0, last_rd});
      issue(0, 1'b0, 1'b1, wa[i], wd[i], lat, err, rd);
      e = sb.pop_front();
      total++;
      if (lat !== 3) begin
        bad++; $display("FAIL wr_lat[%0d] got=%0d want=3", i, lat);
      end
      total++;
      if ({err, rd} !== {e.err, e.rdata}) begin
        bad++; $display("FAIL wr_resp[%0d] got=%b/%h want=%b/%h", i, err, rd, e.err, e.rdata);
      end
    end
    sb.push_back('{1'b0, model[32'h10]});
    last_rd = model[32'h10];
    issue(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, err, rd);
    e = sb.pop_front();
    total++;
    if (lat !== 3) begin
      bad++; $display("FAIL rd_lat got=%0d want=3", lat);
    end
    total++;
    if ({err, rd} !== {e.err, e.rdata}) begin
      bad++; $display("FAIL rd_data got=%b/%h want=%b/%h", err, rd, e.err, e.rdata);
    end
  endtask

  task automatic test_misaligned();
    int          lat;
    logic        err;
    logic [31:0] rd;
    exp_t        e;
    sb.push_back('{1'b1, last_rd});
    issue(0, 1'b1, 1'b0, 32'h12, 32'h0, lat, err, rd);
    e = sb.pop_front();
    total++;
    if (lat !== 1) begin
      bad++; $display("FAIL misal_lat got=%0d want=1", lat);
    end
    total++;
    if ({err, rd} !== {e.err, e.rdata}) begin
      bad++; $display("FAIL misal_resp got=%b/%h want=%b/%h", err, rd, e.err, e.rdata);
    end
  endtask

  task automatic test_bad_requests();
    logic        rds [2];
    logic [31:0] ads [2];
    logic [31:0] rda [2];
    int          lat;
    logic        err;
    logic [31:0] rd;
    exp_t        e;
    rds[0] = 1'b1; ads[0] = 32'h0;
    rds[1] = 1'b0; ads[1] = 32'h400;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b1, last_rd});
      issue(0, rds[i], 1'b1, ads[i], 32'hFFFF0000 | i, lat, err, rd);
      e = sb.pop_front();
      total++;
      if (lat !== 1 || {err, rd} !== {e.err, e.rdata}) begin
        bad++;
        $display("FAIL bad_req[%0d] got=%0d/%b/%h want=1/%b/%h", i, lat, err, rd, e.err, e.rdata);
      end
    end
    rda[0] = 32'h0; rda[1] = 32'h3FC;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b0, model[int'(rda[i])]});
      last_rd = model[int'(rda[i])];
      issue(0, 1'b1, 1'b0, rda[i], 32'h0, lat, err, rd);
      e = sb.pop_front();
      total++;
      if (lat !== 3 || {err, rd} !== {e.err, e.rdata}) begin
        bad++;
        $display("FAIL bad_req_keep[%0d] got=%0d/%b/%h want=3/%b/%h", i, lat, err, rd, e.err, e.rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    int          seen;
    int          lat;
    logic        err;
    logic [31:0] rd;
    exp_t        e;
    seen = 0;
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h20, 32'h12345678);
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.mem_ready) seen++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.mem_ready) seen++;
    end
    last_rd = 32'h0;
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL rst_mid_ready got=%0d pulses want=0", seen);
    end
    total++;
    if (bus.read_data !== 32'h0) begin
      bad++; $display("FAIL rst_mid_rdata got=%h want=00000000", bus.read_data);
    end
    sb.push_back('{1'b0, model[32'h20]});
    last_rd = model[32'h20];
    issue(0, 1'b1, 1'b0, 32'h20, 32'h0, lat, err, rd);
    e = sb.pop_front();
    total++;
    if (lat !== 3 || {err, rd} !== {e.err, e.rdata}) begin
      bad++;
      $display("FAIL rst_mid_keep got=%0d/%b/%h want=3/%b/%h", lat, err, rd, e.err, e.rdata);
    end
  endtask

  task automatic test_back_to_back();
    int   want_c [2];
    int   n;
    exp_t e;
    want_c[0] = 3; want_c[1] = 7;
    n = 0;
    sb.push_back('{1'b0, model[32'h10]});
    sb.push_back('{1'b0, model[32'h20]});
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) bus.address = 32'h20;
      if (c == 5) drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (bus.mem_ready) begin
        total++;
        if (sb.size() == 0 || n > 1) begin
          bad++; $display("FAIL b2b_extra got=ready@%0d want=none", c);
        end else begin
          e = sb.pop_front();
          if (c !== want_c[n] || {bus.mem_error, bus.read_data} !== {e.err, e.rdata}) begin
            bad++;
            $display("FAIL b2b_resp[%0d] got=%0d/%b/%h want=%0d/%b/%h", n, c,
                     bus.mem_error, bus.read_data, want_c[n], e.err, e.rdata);
          end
        end
        n++;
      end
    end
    last_rd = model[32'h20];
    total++;
    if (n !== 2 || sb.size() !== 0) begin
      bad++; $display("FAIL b2b_count got=%0d left=%0d want=2/0", n, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_zero_wait();
    int          lat;
    logic        err;
    logic [31:0] rd;
    int          n;
    exp_t        e;
    model0[4] = 32'h0BADF00D;
    sb.push_back('{1'b0, 32'h0});
    issue(1, 1'b0, 1'b1, 32'h4, 32'h0BADF00D, lat, err, rd);
    e = sb.pop_front();
    total++;
    if (lat !== 1 || {err, rd} !== {e.err, e.rdata}) begin
      bad++; $display("FAIL zw_write got=%0d/%b/%h want=1/%b/%h", lat, err, rd, e.err, e.rdata);
    end
    for (int i = 0; i < 4; i++) sb.push_back('{1'b0, model0[4]});
    n = 0;
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      total++;
      if (bus0.mem_ready !== 1'(c % 2) || bus0.mem_busy !== 1'(c % 2)) begin
        bad++;
        $display("FAIL zw_pattern[%0d] got=ready%b busy%b want=%b", c,
                 bus0.mem_ready, bus0.mem_busy, 1'(c % 2));
      end
      if (bus0.mem_ready && sb.size() != 0) begin
        e = sb.pop_front();
        n++;
        total++;
        if ({bus0.mem_error, bus0.read_data} !== {e.err, e.rdata}) begin
          bad++;
          $display("FAIL zw_data[%0d] got=%b/%h want=%b/%h", c,
                   bus0.mem_error, bus0.read_data, e.err, e.rdata);
        end
      end
      if (c == 8) drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    total++;
    if (n !== 4) begin
      bad++; $display("FAIL zw_count got=%0d want=4", n);
    end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_misaligned();
    test_bad_requests();
    test_reset_mid();
    test_back_to_back();
    test_zero_wait();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
